// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics ROM arbiter.
//   - client ID constants used on gnt_id
//   - FSM state encoding
//   - helper converting a client ID to its one-hot ack vector
package gfx_pkg;

    localparam logic [1:0] ID_BG   = 2'd0;
    localparam logic [1:0] ID_FG   = 2'd1;
    localparam logic [1:0] ID_SPR  = 2'd2;
    localparam logic [1:0] ID_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
        logic [2:0] oh;
        oh = 3'b000;
        case (id)
            ID_BG:   oh = 3'b001;
            ID_FG:   oh = 3'b010;
            ID_SPR:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/gfx_rom_arbiter_if.sv
// Bus bundle between the fetch clients / ROM controller and the arbiter.
//   client side : hb, vb, req[2:0], addr_bg/fg/spr -> arbiter; ack, dout, gnt_id, busy, err <- arbiter
//   ROM side    : rom_addr, rom_cs <- arbiter; rom_data, rom_ok -> arbiter
// The slave modport is the arbiter's view; master is the surrounding system.
interface gfx_rom_arbiter_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic          hb;
    logic          vb;
    logic [2:0]    req;
    logic [AW-1:0] addr_bg;
    logic [AW-1:0] addr_fg;
    logic [AW-1:0] addr_spr;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [DW-1:0] rom_data;
    logic          rom_ok;
    logic [2:0]    ack;
    logic [DW-1:0] dout;
    logic [1:0]    gnt_id;
    logic          busy;
    logic          err;

    modport master (
        output hb, vb, req, addr_bg, addr_fg, addr_spr, rom_data, rom_ok,
        input  rom_addr, rom_cs, ack, dout, gnt_id, busy, err
    );

    modport slave (
        input  hb, vb, req, addr_bg, addr_fg, addr_spr, rom_data, rom_ok,
        output rom_addr, rom_cs, ack, dout, gnt_id, busy, err
    );
endinterface

// File: rtl/prio_pick3.sv
// Combinational three-way priority picker.
//   req[2:0]  : bit0 bg, bit1 fg, bit2 spr
//   blank     : horizontal or vertical blank active
//   force_spr : sprite has been starved, give it the port
//   gnt[2:0]  : one-hot winner (all zero when nothing requests)
//   id[1:0]   : winner ID, ID_NONE when nothing requests
// Blank or starvation puts spr on top; bg still beats fg in every mode.
module prio_pick3
    import gfx_pkg::*;
(
    input  logic [2:0] req,
    input  logic       blank,
    input  logic       force_spr,
    output logic [2:0] gnt,
    output logic [1:0] id
);

    always_comb begin
        gnt = 3'b000;
        id  = ID_NONE;
        if (req[2] && (blank || force_spr)) begin
            gnt = 3'b100;
            id  = ID_SPR;
        end else if (req[0]) begin
            gnt = 3'b001;
            id  = ID_BG;
        end else if (req[1]) begin
            gnt = 3'b010;
            id  = ID_FG;
        end else if (req[2]) begin
            gnt = 3'b100;
            id  = ID_SPR;
        end
    end

endmodule

// File: rtl/gfx_rom_arbiter.sv
// Shares one graphics ROM port among bg tiles, fg tiles and sprites, one
// transaction at a time, with blank-dependent priority, sprite starvation
// override and a WAIT watchdog.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : gfx_rom_arbiter_if.slave (client requests, ROM port, status)
//
// state | meaning
// IDLE  | arbitrate on req, latch winner and its address
// ISSUE | rom_cs high for this single cycle
// WAIT  | wait for rom_ok; watchdog aborts with err and dout=0
// DONE  | one-cycle ack to the owner, dout valid
module gfx_rom_arbiter
    import gfx_pkg::*;
#(
    parameter int AW      = 18,
    parameter int DW      = 16,
    parameter int TIMEOUT = 63,
    parameter int STARVE  = 8
) (
    input  logic             clk,
    input  logic             reset,
    gfx_rom_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE + 1);

    state_t        state, state_nx;
    logic [7:0]    timer;
    logic [SW-1:0] starve_cnt;
    logic [1:0]    gnt_q;
    logic          timed_out;
    logic [AW-1:0] rom_addr_q;
    logic [DW-1:0] dout_q;

    logic [2:0]    pick_gnt;
    logic [1:0]    pick_id;
    logic [AW-1:0] addr_sel;
    logic          force_spr;
    logic          req_any;

    assign force_spr = (starve_cnt == SW'(STARVE));
    assign req_any   = |bus.req;

    prio_pick3 u_pick (
        .req       (bus.req),
        .blank     (bus.hb | bus.vb),
        .force_spr (force_spr),
        .gnt       (pick_gnt),
        .id        (pick_id)
    );

    assign addr_sel = ({AW{pick_gnt[0]}} & bus.addr_bg)
                    | ({AW{pick_gnt[1]}} & bus.addr_fg)
                    | ({AW{pick_gnt[2]}} & bus.addr_spr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        bus.rom_cs = 1'b0;
        bus.ack    = 3'b000;
        bus.err    = 1'b0;
        bus.busy   = (state != ST_IDLE);
        bus.gnt_id = (state == ST_IDLE) ? ID_NONE : gnt_q;
        case (state)
            ST_IDLE:  if (req_any) state_nx = ST_ISSUE;
            ST_ISSUE: begin
                bus.rom_cs = 1'b1;
                state_nx   = ST_WAIT;
            end
            ST_WAIT:  if (bus.rom_ok || timer == 8'd0) state_nx = ST_DONE;
            ST_DONE:  begin
                bus.ack  = id_to_onehot(gnt_q);
                bus.err  = timed_out;
                state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Watchdog is a down-counter loaded in ISSUE: abort on the WAIT edge
    // where it is already zero, giving TIMEOUT+1 WAIT cycles in total.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer      <= 8'd0;
            starve_cnt <= '0;
            gnt_q      <= ID_NONE;
            timed_out  <= 1'b0;
            rom_addr_q <= '0;
            dout_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_any) begin
                    gnt_q      <= pick_id;
                    rom_addr_q <= addr_sel;
                    timed_out  <= 1'b0;
                    if (bus.req[2]) begin
                        if (pick_gnt[2])
                            starve_cnt <= '0;
                        else if (!force_spr)
                            starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                ST_ISSUE: timer <= 8'(TIMEOUT);
                ST_WAIT: begin
                    if (bus.rom_ok) begin
                        dout_q <= bus.rom_data;
                    end else if (timer == 8'd0) begin
                        dout_q    <= '0;
                        timed_out <= 1'b1;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.dout     = dout_q;

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
module tb_gfx_rom_arbiter;
    import gfx_pkg::*;

    localparam int AW      = 18;
    localparam int DW      = 16;
    localparam int TIMEOUT = 63;
    localparam int STARVE  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gfx_rom_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    gfx_rom_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]    ack;
        logic [DW-1:0] dout;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   rom_en;
    bit   rom_pend;
    bit   rom_force;

    localparam logic [AW-1:0] A_BG  = 18'h00100;
    localparam logic [AW-1:0] A_FG  = 18'h20200;
    localparam logic [AW-1:0] A_SPR = 18'h3F300;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hACDB;
    endfunction

    // ROM model: answers with rom_ok in the cycle after it sees rom_cs.
    always @(negedge clk) begin
        if (reset) begin
            rom_pend   = 1'b0;
            bus.rom_ok = 1'b0;
        end else begin
            bus.rom_ok   = rom_pend | rom_force;
            bus.rom_data = rom_force ? 16'h1111 : rom_word(bus.rom_addr);
            rom_pend     = bus.rom_cs && rom_en;
        end
    end

    function automatic void push_exp(input logic [1:0] id, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.ack  = id_to_onehot(id);
        x.dout = d;
        x.err  = e;
        exp_q.push_back(x);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bus.req   = 3'b000;
        bus.hb    = 1'b0;
        bus.vb    = 1'b0;
        rom_force = 1'b0;
        rom_en    = 1'b1;
        bus.addr_bg  = A_BG;
        bus.addr_fg  = A_FG;
        bus.addr_spr = A_SPR;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_monitor(input int max_cycles, input bit drop, input string tag);
        int   cyc = 0;
        exp_t e;
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (bus.ack !== 3'b000) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ack !== e.ack || bus.dout !== e.dout || bus.err !== e.err) begin
                    errors++;
                    $display("FAIL %s: ack=%b dout=%h err=%b, required ack=%b dout=%h err=%b",
                             tag, bus.ack, bus.dout, bus.err, e.ack, e.dout, e.err);
                end
                if (drop) bus.req = bus.req & ~bus.ack;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d transactions outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.rom_cs, bus.rom_addr, bus.ack, bus.dout, bus.err, bus.busy, bus.gnt_id} !==
            {1'b0, 18'h0, 3'b000, 16'h0, 1'b0, 1'b0, ID_NONE}) begin
            errors++;
            $display("FAIL reset_values: cs=%b addr=%h ack=%b dout=%h err=%b busy=%b gnt=%0d, required all zero gnt=3",
                     bus.rom_cs, bus.rom_addr, bus.ack, bus.dout, bus.err, bus.busy, bus.gnt_id);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt_id !== ID_NONE) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b gnt=%0d, required busy=0 gnt=3", bus.busy, bus.gnt_id);
        end
    endtask

    task automatic test_single_bg();
        exp_t e;
        do_reset();
        bus.addr_bg = 18'h01234;
        bus.req     = 3'b001;
        push_exp(ID_BG, 16'hBEEF, 1'b0);
        @(negedge clk);
        checks++;
        if ({bus.rom_cs, bus.rom_addr, bus.gnt_id, bus.busy} !== {1'b1, 18'h01234, ID_BG, 1'b1}) begin
            errors++;
            $display("FAIL single_issue: cs=%b addr=%h gnt=%0d busy=%b, required cs=1 addr=01234 gnt=0 busy=1",
                     bus.rom_cs, bus.rom_addr, bus.gnt_id, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.rom_cs !== 1'b0 || bus.ack !== 3'b000) begin
            errors++;
            $display("FAIL single_cs_width: cs=%b ack=%b, required cs=0 ack=000", bus.rom_cs, bus.ack);
        end
        @(negedge clk);
        checks++;
        if (bus.ack === 3'b000) begin
            errors++;
            $display("FAIL single_latency: ack=%b at cycle 3, required ack", bus.ack);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if (bus.ack !== e.ack || bus.dout !== e.dout || bus.err !== e.err) begin
                errors++;
                $display("FAIL single_data: ack=%b dout=%h err=%b, required ack=%b dout=%h err=%b",
                         bus.ack, bus.dout, bus.err, e.ack, e.dout, e.err);
            end
        end
        bus.req = 3'b000;
        @(negedge clk);
        checks++;
        if ({bus.ack, bus.busy, bus.gnt_id} !== {3'b000, 1'b0, ID_NONE}) begin
            errors++;
            $display("FAIL single_return_idle: ack=%b busy=%b gnt=%0d, required 000 0 3",
                     bus.ack, bus.busy, bus.gnt_id);
        end
    endtask

    task automatic test_order(input bit blank);
        do_reset();
        bus.hb = blank;
        if (blank) begin
            push_exp(ID_SPR, rom_word(A_SPR), 1'b0);
            push_exp(ID_BG,  rom_word(A_BG),  1'b0);
            push_exp(ID_FG,  rom_word(A_FG),  1'b0);
        end else begin
            push_exp(ID_BG,  rom_word(A_BG),  1'b0);
            push_exp(ID_FG,  rom_word(A_FG),  1'b0);
            push_exp(ID_SPR, rom_word(A_SPR), 1'b0);
        end
        bus.req = 3'b111;
        run_monitor(60, 1'b1, blank ? "order_blank" : "order_active");
        bus.req = 3'b000;
    endtask

    task automatic test_starve();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < STARVE; i++) push_exp(ID_BG, rom_word(A_BG), 1'b0);
            push_exp(ID_SPR, rom_word(A_SPR), 1'b0);
        end
        bus.req = 3'b101;
        run_monitor(200, 1'b0, "starve");
        bus.req = 3'b000;
    endtask

    task automatic test_timeout();
        int   n = 0;
        bit   seen = 1'b0;
        bit   stray = 1'b0;
        exp_t e;
        do_reset();
        rom_en      = 1'b0;
        bus.addr_bg = 18'h00ABC;
        bus.req     = 3'b001;
        push_exp(ID_BG, 16'h0000, 1'b1);
        while (!seen && n < 120) begin
            @(negedge clk);
            n++;
            if (bus.ack !== 3'b000) seen = 1'b1;
        end
        checks++;
        if (n != TIMEOUT + 3) begin
            errors++;
            $display("FAIL timeout_latency: ack after %0d cycles, required %0d", n, TIMEOUT + 3);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_ack: no ack, required ack");
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if (bus.ack !== e.ack || bus.dout !== e.dout || bus.err !== e.err) begin
                errors++;
                $display("FAIL timeout_data: ack=%b dout=%h err=%b, required ack=%b dout=%h err=%b",
                         bus.ack, bus.dout, bus.err, e.ack, e.dout, e.err);
            end
        end
        bus.req = 3'b000;
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_width: err=%b one cycle later, required 0", bus.err);
        end
        rom_force = 1'b1;
        repeat (2) @(negedge clk);
        rom_force = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack !== 3'b000 || bus.err !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL late_rom_ok: activity after late rom_ok, required none");
        end
        rom_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit stray = 1'b0;
        do_reset();
        rom_en  = 1'b0;
        bus.req = 3'b001;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.gnt_id !== ID_BG) begin
            errors++;
            $display("FAIL mid_setup: busy=%b gnt=%0d, required busy=1 gnt=0", bus.busy, bus.gnt_id);
        end
        reset   = 1'b1;
        bus.req = 3'b010;
        #1;
        checks++;
        if ({bus.rom_cs, bus.rom_addr, bus.ack, bus.dout, bus.err, bus.busy, bus.gnt_id} !==
            {1'b0, 18'h0, 3'b000, 16'h0, 1'b0, 1'b0, ID_NONE}) begin
            errors++;
            $display("FAIL mid_reset_values: cs=%b addr=%h ack=%b dout=%h err=%b busy=%b gnt=%0d, required all zero gnt=3",
                     bus.rom_cs, bus.rom_addr, bus.ack, bus.dout, bus.err, bus.busy, bus.gnt_id);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.ack !== 3'b000 || bus.err !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL mid_reset_ack: ack or err during reset, required none");
        end
        rom_en = 1'b1;
        reset  = 1'b0;
        push_exp(ID_FG, rom_word(A_FG), 1'b0);
        run_monitor(20, 1'b1, "after_reset");
        bus.req = 3'b000;
    endtask

    task automatic test_blank_switch();
        do_reset();
        bus.req = 3'b001;
        push_exp(ID_BG,  rom_word(A_BG),  1'b0);
        push_exp(ID_SPR, rom_word(A_SPR), 1'b0);
        @(negedge clk);
        bus.hb  = 1'b1;
        bus.req = 3'b101;
        checks++;
        if (bus.gnt_id !== ID_BG) begin
            errors++;
            $display("FAIL blank_owner: gnt=%0d, required 0", bus.gnt_id);
        end
        run_monitor(30, 1'b0, "blank_switch");
        bus.req = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        rom_en    = 1'b1;
        rom_force = 1'b0;
        bus.req   = 3'b000;
        bus.hb    = 1'b0;
        bus.vb    = 1'b0;
        bus.addr_bg  = A_BG;
        bus.addr_fg  = A_FG;
        bus.addr_spr = A_SPR;
        test_reset();
        test_single_bg();
        test_order(1'b0);
        test_order(1'b1);
        test_starve();
        test_timeout();
        test_reset_mid();
        test_blank_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gfx_rom_arbiter.md
# gfx_rom_arbiter

Sequencer that shares one graphics ROM port among three fetch clients: background tiles, foreground tiles and sprites. It sits between the layer fetch engines and the SDRAM/ROM controller. It takes the horizontal and vertical blank flags from the video timing generator and uses them to swap priorities, so sprite line-buffer fills get the port during blanking and tile fetches get it during active display. Only one ROM transaction is outstanding at a time. A watchdog guarantees forward progress.

## Interface
- AW, 18: ROM byte-address width
- DW, 16: ROM data width
- TIMEOUT, 63: max WAIT cycles before abort, 1..255
- STARVE, 8: consecutive lost arbitrations after which sprite is forced top priority
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- hb  in  1  horizontal blank from timing generator
- vb  in  1  vertical blank from timing generator
- req  in  3  request level per client; bit0=bg, bit1=fg, bit2=spr
- addr_bg, addr_fg, addr_spr  in  AW  client addresses; held stable while req high
- rom_addr  out  AW  registered ROM address
- rom_cs  out  1  one-cycle ROM strobe
- rom_data  in  DW  ROM read data
- rom_ok  in  1  ROM data-valid
- ack  out  3  one-hot one-cycle completion pulse
- dout  out  DW  read data, valid when any ack bit is high
- gnt_id  out  2  current owner (0 bg, 1 fg, 2 spr, 3 none)
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on timeout

## Operation
- FSM states:
  - IDLE: sample req; if nonzero, pick winner, latch address, go to ISSUE; else stay.
  - ISSUE: rom_cs=1 for exactly one cycle, then go to WAIT.
  - WAIT: on rom_ok, capture rom_data into dout and go to DONE. Otherwise increment the timer; when it reaches TIMEOUT, set dout=0, pulse err, go to DONE.
  - DONE: ack[gnt]=1, then go to IDLE.
- Priority:
  - hb|vb=1: spr > bg > fg.
  - Otherwise: bg > fg > spr.
  - hb/vb are sampled only in IDLE. A blank edge mid-transaction does not affect the current owner.
- Starvation:
  - A counter increments when spr requests in IDLE but loses. It clears when spr wins.
  - When the count reaches STARVE, spr wins regardless of blanking. The counter saturates at STARVE.
- Requester rule: drop req on the edge at which ack is observed. A req still high in the following IDLE is a new request.
- rom_ok is ignored in IDLE, ISSUE and DONE. A late rom_ok after a timeout is discarded.
- Reset values:
  - State IDLE.
  - rom_cs=0, rom_addr=0, ack=0, dout=0, err=0, busy=0, gnt_id=3.
  - Timer and starvation counter 0.
- Reset mid-transaction: return to IDLE immediately; no ack and no err is generated for the aborted transaction.

## Timing
- req high at edge E0 (IDLE): ISSUE after E0 (rom_cs, rom_addr valid), WAIT after E1.
- rom_ok high in the first WAIT cycle, sampled at E2: DONE after E2, ack/dout visible E2..E3, IDLE after E3.
- Minimum latency: req sampled to ack = 3 cycles. Minimum period: 4 cycles per transaction.
- Timeout: ack occurs TIMEOUT cycles after entering WAIT, plus 1.
- gnt_id is valid from ISSUE through DONE; it reads 3 in IDLE.

## Structure
- Shared package gfx_pkg holds:
  - Client ID constants ID_BG=0, ID_FG=1, ID_SPR=2, ID_NONE=3.
  - FSM state encoding.
- Sub-module prio_pick3 is combinational. It takes req[2:0], blank and force_spr, and outputs a one-hot grant plus a 2-bit ID. It is instantiated once; the top level holds the FSM, timer and starvation counter.

## Test plan
- Single bg request at addr 0x01234, hb=vb=0, ROM returning 0xBEEF one cycle after cs: rom_addr=0x01234, rom_cs exactly 1 cycle, ack=3'b001 with dout=0xBEEF, 3 cycles after req is sampled.
- req=3'b111 held with ROM answering immediately:
  - hb=0: grant order bg, fg, spr.
  - hb=1: grant order spr, bg, fg.
  - No ack overlaps.
- spr requesting continuously while bg re-requests every IDLE, STARVE=8: after 8 losses spr wins on the 9th arbitration; the counter then clears.
- rom_ok never asserted, TIMEOUT=63: err pulse and ack with dout=0 64 cycles after entering WAIT; a rom_ok arriving afterwards causes no ack.
- reset asserted during WAIT: outputs go to reset values at once; no ack. After release, a pending fg request completes normally.
- hb rising during a bg transaction while spr also requests: bg completes first, then spr wins the next IDLE.
